// File: rtl/decode_insn_queue_pkg.sv
// Shared fetch/decode types for the instruction queue between fetch and decode.
// Field widths come from the machine-wide M_WIDTH and LG_PHT_SZ macros.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

package decode_insn_queue_pkg;

    localparam int M_W   = `M_WIDTH;
    localparam int PHT_W = `LG_PHT_SZ;

    typedef struct packed {
        logic [31:0]      insn;
        logic [M_W-1:0]   pc;
        logic             pred;
        logic [PHT_W-1:0] pht_idx;
        logic [M_W-1:0]   pred_target;
    } fetch_entry_t;

    function automatic int af_level(input int lg_q_sz);
        return (1 << lg_q_sz) - 2;
    endfunction

endpackage

// File: rtl/decode_insn_queue_if.sv
// Fetch-to-decode queue handshake bundle.
// slave = the queue itself, master = the fetch/decode side driving it.
interface decode_insn_queue_if #(
    parameter int LG_Q_SZ = 3,
    parameter int W       = decode_insn_queue_pkg::M_W
);
    localparam int PW = decode_insn_queue_pkg::PHT_W;

    logic             flush;
    logic             enq_valid;
    logic [31:0]      enq_insn;
    logic [W-1:0]     enq_pc;
    logic             enq_pred;
    logic [PW-1:0]    enq_pht_idx;
    logic [W-1:0]     enq_pred_target;
    logic             enq_ready;
    logic             almost_full;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      insn;
    logic [W-1:0]     pc;
    logic             insn_pred;
    logic [PW-1:0]    pht_idx;
    logic [W-1:0]     insn_pred_target;
    logic [LG_Q_SZ:0] occupancy;

    modport slave (
        input  flush, enq_valid, enq_insn, enq_pc, enq_pred,
        input  enq_pht_idx, enq_pred_target, deq_ready,
        output enq_ready, almost_full, deq_valid, insn, pc,
        output insn_pred, pht_idx, insn_pred_target, occupancy
    );

    modport master (
        output flush, enq_valid, enq_insn, enq_pc, enq_pred,
        output enq_pht_idx, enq_pred_target, deq_ready,
        input  enq_ready, almost_full, deq_valid, insn, pc,
        input  insn_pred, pht_idx, insn_pred_target, occupancy
    );

endinterface

// File: rtl/decode_insn_queue.sv
// Circular instruction buffer between fetch and decode_riscv.
// Head outputs come straight from registered storage; no enq-to-deq bypass.
module decode_insn_queue
    import decode_insn_queue_pkg::*;
#(
    parameter int LG_Q_SZ = 3,
    parameter int W       = M_W
) (
    input  logic clk,
    input  logic reset,
    decode_insn_queue_if.slave q
);

    localparam int Q_SZ = 1 << LG_Q_SZ;

    typedef logic [LG_Q_SZ:0] ptr_t;

    fetch_entry_t r_mem [Q_SZ];
    ptr_t         r_head;
    ptr_t         r_tail;

    logic         w_empty;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    ptr_t         w_occ;
    fetch_entry_t w_enq_e;
    fetch_entry_t w_head_e;

    always_comb begin
        w_empty = (r_head == r_tail);
        w_full  = (r_head[LG_Q_SZ-1:0] == r_tail[LG_Q_SZ-1:0])
               && (r_head[LG_Q_SZ] != r_tail[LG_Q_SZ]);
        // flush wins over both sides of the handshake
        w_push  = q.enq_valid && !w_full && !q.flush;
        w_pop   = q.deq_ready && !w_empty && !q.flush;
        w_occ   = r_tail - r_head;
    end

    always_comb begin
        w_enq_e             = '0;
        w_enq_e.insn        = q.enq_insn;
        w_enq_e.pc          = q.enq_pc;
        w_enq_e.pred        = q.enq_pred;
        w_enq_e.pht_idx     = q.enq_pht_idx;
        w_enq_e.pred_target = q.enq_pred_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Q_SZ; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_tail[LG_Q_SZ-1:0]] <= w_enq_e;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (q.flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + ptr_t'(1);
            end
            if (w_pop) begin
                r_head <= r_head + ptr_t'(1);
            end
        end
    end

    assign w_head_e = r_mem[r_head[LG_Q_SZ-1:0]];

    assign q.enq_ready        = !w_full;
    assign q.deq_valid        = !w_empty;
    assign q.occupancy        = w_occ;
    assign q.almost_full      = (w_occ >= ptr_t'(af_level(LG_Q_SZ)));
    assign q.insn             = w_head_e.insn;
    assign q.pc               = w_head_e.pc;
    assign q.insn_pred        = w_head_e.pred;
    assign q.pht_idx          = w_head_e.pht_idx;
    assign q.insn_pred_target = w_head_e.pred_target;

    a_fetch_proto: assert property (@(posedge clk) disable iff (reset)
        !(q.enq_valid && !q.enq_ready && !q.flush))
        else $error("fetch pushed into a full instruction queue");

    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        w_occ <= ptr_t'(Q_SZ))
        else $error("instruction queue occupancy out of range");

endmodule

// File: tb/tb_decode_insn_queue.sv
// Bench for decode_insn_queue: queue-based reference model with per-cycle compare,
// directed fill/drain/flush/async-reset scenarios and a randomized wrap run.
module tb_decode_insn_queue;
    import decode_insn_queue_pkg::*;

    localparam int LG = 3;
    localparam int QN = 1 << LG;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int max_occ = 0;

    fetch_entry_t mq[$];

    decode_insn_queue_if #(.LG_Q_SZ(LG)) qi ();

    decode_insn_queue #(.LG_Q_SZ(LG)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (qi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        fetch_entry_t e;
        bit was_full;
        if (reset || qi.flush) begin
            mq.delete();
            return;
        end
        was_full      = (mq.size() == QN);
        e.insn        = qi.enq_insn;
        e.pc          = qi.enq_pc;
        e.pred        = qi.enq_pred;
        e.pht_idx     = qi.enq_pht_idx;
        e.pred_target = qi.enq_pred_target;
        if (qi.deq_ready && mq.size() != 0) void'(mq.pop_front());
        if (qi.enq_valid && !was_full) mq.push_back(e);
    endtask

    always @(posedge clk or posedge reset) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", 64'(qi.occupancy), 64'(mq.size()));
            check("deq_valid", 64'(qi.deq_valid), 64'(mq.size() != 0));
            check("enq_ready", 64'(qi.enq_ready), 64'(mq.size() != QN));
            check("almost_full", 64'(qi.almost_full), 64'(mq.size() >= QN - 2));
            if (mq.size() != 0) begin
                check("head_insn", 64'(qi.insn), 64'(mq[0].insn));
                check("head_pc", 64'(qi.pc), 64'(mq[0].pc));
                check("head_pred", 64'(qi.insn_pred), 64'(mq[0].pred));
                check("head_pht", 64'(qi.pht_idx), 64'(mq[0].pht_idx));
                check("head_tgt", 64'(qi.insn_pred_target), 64'(mq[0].pred_target));
            end
            if (int'(qi.occupancy) > max_occ) max_occ = int'(qi.occupancy);
        end
    end

    task automatic set_in(input logic v, input logic [31:0] ins,
                          input logic [M_W-1:0] pc, input logic pred,
                          input logic [PHT_W-1:0] pht, input logic [M_W-1:0] tgt,
                          input logic dr, input logic fl);
        qi.enq_valid       = v;
        qi.enq_insn        = ins;
        qi.enq_pc          = pc;
        qi.enq_pred        = pred;
        qi.enq_pht_idx     = pht;
        qi.enq_pred_target = tgt;
        qi.deq_ready       = dr;
        qi.flush           = fl;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [M_W-1:0] pc, input logic pred,
                         input logic [PHT_W-1:0] pht, input logic [M_W-1:0] tgt,
                         input logic dr, input logic fl);
        set_in(v, ins, pc, pred, pht, tgt, dr, fl);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] ins, input logic [M_W-1:0] pc,
                        input logic dr);
        drive(1'b1, ins, pc, pc[2], pc[PHT_W-1:0], pc + 'h40, dr, 1'b0);
    endtask

    task automatic idle(input logic dr);
        drive(1'b0, '0, '0, 1'b0, '0, '0, dr, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * QN && mq.size() != 0; i++) idle(1'b1);
        check("drained", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M_W-1:0] lst [7];
        logic [31:0] r;
        int pushes;
        int cyc;
        logic v;

        reset = 1'b1;
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_deq_valid", 64'(qi.deq_valid), 64'd0);
        check("rst_enq_ready", 64'(qi.enq_ready), 64'd1);
        check("rst_almost_full", 64'(qi.almost_full), 64'd0);
        check("rst_occupancy", 64'(qi.occupancy), 64'd0);
        check("rst_insn", 64'(qi.insn), 64'd0);
        check("rst_pc", 64'(qi.pc), 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // single push, one-cycle latency
        push(32'h00a00093, 'h1000, 1'b0);
        check("single_valid", 64'(qi.deq_valid), 64'd1);
        check("single_insn", 64'(qi.insn), 64'h00a00093);
        check("single_pc", 64'(qi.pc), 64'h1000);
        check("single_occ", 64'(qi.occupancy), 64'd1);
        drain();

        // fill to full without popping, then drain in order
        for (int i = 0; i < QN; i++) begin
            push($urandom, M_W'(i * 4), 1'b0);
            if (i == 4) check("af_after5", 64'(qi.almost_full), 64'd0);
            if (i == 5) check("af_after6", 64'(qi.almost_full), 64'd1);
        end
        check("full_enq_ready", 64'(qi.enq_ready), 64'd0);
        check("full_occ", 64'(qi.occupancy), 64'd8);
        for (int i = 0; i < QN; i++) begin
            check("drain_pc", 64'(qi.pc), 64'(i * 4));
            idle(1'b1);
            if (i == 0) check("ready_after_pop", 64'(qi.enq_ready), 64'd1);
        end
        check("drain_empty", 64'(qi.deq_valid), 64'd0);

        // randomized run across pointer wrap
        pushes = 0;
        for (cyc = 0; cyc < 400 && pushes < 20; cyc++) begin
            r = $urandom;
            v = (mq.size() < QN) && (r[1:0] != 2'b00);
            drive(v, $urandom, M_W'($urandom), r[4], r[PHT_W+4:5],
                  M_W'($urandom), r[31] | r[30], 1'b0);
            if (v) pushes++;
        end
        check("wrap_pushes", 64'(pushes), 64'd20);
        drain();
        check("max_occ_le_8", 64'(max_occ <= QN), 64'd1);

        // simultaneous push/pop at occupancy 3
        lst = '{'h100, 'h104, 'h108, 'h200, 'h204, 'h208, 'h20c};
        for (int i = 0; i < 3; i++) push($urandom, lst[i], 1'b0);
        check("pp_occ_start", 64'(qi.occupancy), 64'd3);
        for (int k = 0; k < 4; k++) begin
            check("pp_head_pc", 64'(qi.pc), 64'(lst[k]));
            push($urandom, lst[k+3], 1'b1);
            check("pp_occ", 64'(qi.occupancy), 64'd3);
        end
        drain();

        // flush with push and pop requested at occupancy 5
        for (int i = 0; i < 5; i++) push($urandom, M_W'('h300 + i * 4), 1'b0);
        check("fl_occ_before", 64'(qi.occupancy), 64'd5);
        drive(1'b1, 32'hdeadbeef, 'hdead0, 1'b1, '1, 'hbeef0, 1'b1, 1'b1);
        check("fl_occ", 64'(qi.occupancy), 64'd0);
        check("fl_deq_valid", 64'(qi.deq_valid), 64'd0);
        idle(1'b0);
        check("fl_still_empty", 64'(qi.deq_valid), 64'd0);
        push(32'h00000013, 'h400, 1'b0);
        check("fl_next_pc", 64'(qi.pc), 64'h400);
        check("fl_next_occ", 64'(qi.occupancy), 64'd1);
        drain();

        // asynchronous reset pulse between clock edges at occupancy 4
        for (int i = 0; i < 4; i++) push($urandom, M_W'('h500 + i * 4), 1'b0);
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        check("ar_occ_before", 64'(qi.occupancy), 64'd4);
        #2 reset = 1'b1;
        #1;
        check("ar_deq_valid", 64'(qi.deq_valid), 64'd0);
        check("ar_occ", 64'(qi.occupancy), 64'd0);
        check("ar_enq_ready", 64'(qi.enq_ready), 64'd1);
        #1 reset = 1'b0;
        @(negedge clk);
        push(32'h00100113, 'h600, 1'b0);
        check("ar_resume_pc", 64'(qi.pc), 64'h600);
        check("ar_resume_insn", 64'(qi.insn), 64'h00100113);
        drain();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
